// File: rtl/poly_synth_pkg.sv
// Shared types and helpers for the polyphonic oscillator engine.
//   wave_t       : per-voice waveform select
//   LFSR_SEED    : noise generator reset value
//   LFSR_MASK    : Galois feedback taps
//   lfsr_step    : one Galois LFSR step
//   sat_to_width : clamp a signed value to a signed range of w bits
package poly_synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Limits are built in 64 bits so w up to 32 does not overflow.
  function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] val, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (longint'(val) > hi) return 32'(hi);
    if (longint'(val) < lo) return 32'(lo);
    return val;
  endfunction

endpackage

// File: rtl/poly_synth_wavegen.sv
// Combinational waveform stage shared by all voices.
//   phase_top : top SAMPLE_W bits of the voice phase (unsigned)
//   wave      : waveform select
//   lfsr      : current noise register
//   sample    : signed oscillator sample
module poly_synth_wavegen
  import poly_synth_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic [SAMPLE_W-1:0]        phase_top,
  input  wave_t                      wave,
  input  logic [15:0]                lfsr,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic                msb;
  logic [SAMPLE_W-2:0] q;

  always_comb begin
    msb = phase_top[SAMPLE_W-1];
    // Triangle folds the second half of the period back down.
    q   = msb ? ~phase_top[SAMPLE_W-2:0] : phase_top[SAMPLE_W-2:0];
    case (wave)
      WAVE_SQUARE: sample = msb ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
      WAVE_SAW:    sample = {~msb, phase_top[SAMPLE_W-2:0]};
      WAVE_TRI:    sample = {~q[SAMPLE_W-2], q[SAMPLE_W-3:0], 1'b0};
      default:     sample = SAMPLE_W'($signed(lfsr));
    endcase
  end

endmodule

// File: rtl/poly_synth_engine.sv
// Time-multiplexed polyphonic DDS oscillator engine. Each sample_tick sweeps
// all voices through read/increment, waveform and scale/accumulate stages and
// emits one saturated mixed sample.
//   clk, reset         : clock, async active-high reset
//   sample_tick        : starts a sweep when idle
//   cfg_*              : per-voice increment/volume/wave write, optional phase clear
//   out, out_valid     : mixed sample and its one-cycle update pulse
//   busy               : sweep in progress
//   overrun, clip      : sticky status flags
module poly_synth_engine
  import poly_synth_pkg::*;
#(
  parameter int VOICES   = 8,
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16,
  parameter int VOL_W    = 8,
  parameter int OUT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [$clog2(VOICES)-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0]         cfg_incr,
  input  logic [VOL_W-1:0]           cfg_vol,
  input  logic [1:0]                 cfg_wave,
  input  logic                       cfg_phase_rst,
  output logic signed [OUT_W-1:0]    out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun,
  output logic                       clip
);

  localparam int VIDX_W = $clog2(VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(VOICES - 1);

  logic [PHASE_W-1:0] phase_mem [VOICES];
  logic [PHASE_W-1:0] incr_mem  [VOICES];
  logic [VOL_W-1:0]   vol_mem   [VOICES];
  wave_t              wave_mem  [VOICES];
  logic [15:0]        lfsr;

  logic                       s0_active;
  logic [VIDX_W-1:0]          s0_idx;
  logic                       s1_valid, s1_first, s1_last;
  logic [SAMPLE_W-1:0]        s1_phase_top;
  wave_t                      s1_wave;
  logic [VOL_W-1:0]           s1_vol;
  logic                       s2_valid, s2_first, s2_last;
  logic signed [SAMPLE_W-1:0] s2_sample;
  logic [VOL_W-1:0]           s2_vol;
  logic signed [ACC_W-1:0]    acc;

  logic                       accept;
  logic signed [SAMPLE_W-1:0] wave_sample;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    term, acc_sum;
  logic signed [31:0]         acc_ext, sat_val;
  logic                       sat_hit;

  assign accept = sample_tick && !busy;

  poly_synth_wavegen #(.SAMPLE_W(SAMPLE_W)) u_wavegen (
    .phase_top (s1_phase_top),
    .wave      (s1_wave),
    .lfsr      (lfsr),
    .sample    (wave_sample)
  );

  always_comb begin
    prod    = PROD_W'(s2_sample) * PROD_W'($signed({1'b0, s2_vol}));
    term    = ACC_W'(prod >>> VOL_W);
    acc_sum = s2_first ? term : acc + term;
    acc_ext = 32'(acc_sum);
    sat_val = sat_to_width(acc_ext, OUT_W);
    sat_hit = (sat_val != acc_ext);
  end

  // Voice state. The config write comes last so a phase clear to the voice
  // currently in stage 0 overrides its increment write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_mem[v] <= '0;
        incr_mem[v]  <= '0;
        vol_mem[v]   <= '0;
        wave_mem[v]  <= WAVE_SQUARE;
      end
    end else begin
      if (s0_active) phase_mem[s0_idx] <= phase_mem[s0_idx] + incr_mem[s0_idx];
      if (cfg_we) begin
        incr_mem[cfg_voice] <= cfg_incr;
        vol_mem[cfg_voice]  <= cfg_vol;
        wave_mem[cfg_voice] <= wave_t'(cfg_wave);
        if (cfg_phase_rst) phase_mem[cfg_voice] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr         <= LFSR_SEED;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      clip         <= 1'b0;
      out          <= '0;
      out_valid    <= 1'b0;
      s0_active    <= 1'b0;
      s0_idx       <= '0;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_phase_top <= '0;
      s1_wave      <= WAVE_SQUARE;
      s1_vol       <= '0;
      s2_valid     <= 1'b0;
      s2_first     <= 1'b0;
      s2_last      <= 1'b0;
      s2_sample    <= '0;
      s2_vol       <= '0;
      acc          <= '0;
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && busy) overrun <= 1'b1;

      // The LFSR advances once at sweep start so every noise voice in the
      // sweep sees the same value.
      if (accept) begin
        busy      <= 1'b1;
        s0_active <= 1'b1;
        s0_idx    <= '0;
        lfsr      <= lfsr_step(lfsr);
      end else if (s0_active) begin
        s0_idx <= s0_idx + VIDX_W'(1);
        if (s0_idx == LAST_IDX) s0_active <= 1'b0;
      end

      s1_valid     <= s0_active;
      s1_first     <= (s0_idx == '0);
      s1_last      <= (s0_idx == LAST_IDX);
      s1_phase_top <= phase_mem[s0_idx][PHASE_W-1 -: SAMPLE_W];
      s1_wave      <= wave_mem[s0_idx];
      s1_vol       <= vol_mem[s0_idx];

      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_sample <= wave_sample;
      s2_vol    <= s1_vol;

      if (s2_valid) begin
        acc <= acc_sum;
        if (s2_last) begin
          out       <= sat_val[OUT_W-1:0];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          if (sat_hit) clip <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_synth_engine.sv
module tb_poly_synth_engine;

  localparam int VOICES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_voice = '0;
  logic [23:0] cfg_incr = '0;
  logic [7:0]  cfg_vol = '0;
  logic [1:0]  cfg_wave = '0;
  logic        cfg_phase_rst = 1'b0;
  logic signed [15:0] out;
  logic        out_valid, busy, overrun, clip;

  typedef struct {
    int out;
    int clip;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int nvalid = 0;

  int m_phase[VOICES];
  int m_incr[VOICES];
  int m_vol[VOICES];
  int m_wave[VOICES];
  int m_lfsr;
  int m_clip;

  always #5 clk = ~clk;

  poly_synth_engine dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .cfg_we        (cfg_we),
    .cfg_voice     (cfg_voice),
    .cfg_incr      (cfg_incr),
    .cfg_vol       (cfg_vol),
    .cfg_wave      (cfg_wave),
    .cfg_phase_rst (cfg_phase_rst),
    .out           (out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .clip          (clip)
  );

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_phase[v] = 0; m_incr[v] = 0; m_vol[v] = 0; m_wave[v] = 0;
    end
    m_lfsr = 'hACE1;
    m_clip = 0;
  endfunction

  function automatic int model_wave(int w, int ph);
    int p, s, qq;
    p = (ph >> 8) & 'hFFFF;
    case (w)
      0: s = (p >= 32768) ? -32768 : 32767;
      1: s = p - 32768;
      2: begin
        qq = (p >= 32768) ? 32767 - (p - 32768) : p;
        s = 2 * qq - 32768;
      end
      default: s = (m_lfsr >= 32768) ? m_lfsr - 65536 : m_lfsr;
    endcase
    return s;
  endfunction

  // One sweep of the reference model; pushes the expected output.
  function automatic void model_sweep(bit clear_v0);
    int acc;
    exp_t e;
    m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
    acc = 0;
    for (int v = 0; v < VOICES; v++) begin
      acc += (model_wave(m_wave[v], m_phase[v]) * m_vol[v]) >>> 8;
      m_phase[v] = (m_phase[v] + m_incr[v]) & 'hFFFFFF;
    end
    if (clear_v0) m_phase[0] = 0;
    if (acc > 32767) begin e.out = 32767; m_clip = 1; end
    else if (acc < -32768) begin e.out = -32768; m_clip = 1; end
    else e.out = acc;
    e.clip = m_clip;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid) begin
      nvalid++;
      if (q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("out", int'(out), e.out);
        check("clip", int'(clip), e.clip);
      end
    end
  end

  task automatic cfg(int v, int incr, int vol, int w, bit prst);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = 3'(v); cfg_incr = 24'(incr);
    cfg_vol = 8'(vol); cfg_wave = 2'(w); cfg_phase_rst = prst;
    m_incr[v] = incr; m_vol[v] = vol; m_wave[v] = w;
    if (prst) m_phase[v] = 0;
    @(negedge clk);
    cfg_we = 1'b0; cfg_phase_rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic sweep();
    @(negedge clk);
    sample_tick = 1'b1;
    model_sweep(1'b0);
    @(negedge clk);
    sample_tick = 1'b0;
    wait_drain();
  endtask

  initial begin
    int busy_cnt, first_valid, nv0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_clip", int'(clip), 0);

    // Timing of one sweep with every voice muted.
    @(negedge clk);
    sample_tick = 1'b1;
    model_sweep(1'b0);
    busy_cnt = 0; first_valid = -1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      if (busy) busy_cnt++;
      if (out_valid && first_valid < 0) first_valid = k;
      if (k == 1) check("busy_after_tick", int'(busy), 1);
      if (k == 11) check("busy_low_at_valid", int'(busy), 0);
    end
    check("busy_cycles", busy_cnt, 10);
    check("valid_latency", first_valid, 11);
    wait_drain();

    // Square on voice 0 toggling every sweep.
    cfg(0, 1 << 23, 255, 0, 1'b1);
    repeat (4) sweep();

    // Saw stepping a quarter period per sweep, then a phase restart.
    cfg(0, 1 << 22, 255, 1, 1'b1);
    repeat (6) sweep();
    cfg(0, 1 << 22, 255, 1, 1'b1);
    repeat (2) sweep();

    // Phase clear landing on voice 0 while it is in stage 0.
    @(negedge clk);
    sample_tick = 1'b1;
    model_sweep(1'b1);
    @(negedge clk);
    sample_tick = 1'b0;
    cfg_we = 1'b1; cfg_voice = 3'd0; cfg_incr = 24'(1 << 22);
    cfg_vol = 8'd255; cfg_wave = 2'd1; cfg_phase_rst = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_phase_rst = 1'b0;
    wait_drain();
    sweep();

    // Tick during an active sweep.
    check("overrun_pre", int'(overrun), 0);
    nv0 = nvalid;
    @(negedge clk);
    sample_tick = 1'b1;
    model_sweep(1'b0);
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check("overrun_set", int'(overrun), 1);
    wait_drain();
    repeat (15) @(negedge clk);
    check("overrun_single_valid", nvalid - nv0, 1);

    // Saw plus triangle on two voices with partial volume.
    cfg(0, 1 << 22, 128, 1, 1'b0);
    cfg(1, 'h0A0000, 64, 2, 1'b1);
    repeat (4) sweep();

    // All voices square at full volume saturate; clip stays set afterwards.
    for (int v = 0; v < VOICES; v++) cfg(v, 0, 255, 0, 1'b1);
    sweep();
    for (int v = 0; v < VOICES; v++) cfg(v, 0, 0, 0, 1'b0);
    sweep();
    check("clip_sticky", int'(clip), 1);

    // Noise on two voices over many sweeps.
    cfg(0, 'h10000, 255, 3, 1'b0);
    cfg(5, 'h00100, 77, 3, 1'b0);
    repeat (100) sweep();

    // Reset in the middle of a sweep.
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    check("midrst_out", int'(out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_clip", int'(clip), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nv0 = nvalid;
    repeat (15) @(negedge clk);
    check("midrst_no_valid", nvalid - nv0, 0);
    check("midrst_out_after", int'(out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
